// File: rtl/fft_pingpong_stage_ram_if.sv
// Handshake bundle for the radix-4 FFT ping-pong inter-stage buffer.
// Word layout defaults come from MAN_WIDTH/EXP_WIDTH when not set by the build.
`ifndef MAN_WIDTH
`define MAN_WIDTH 16
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 8
`endif

interface fft_pingpong_stage_ram_if #(
    parameter int DATA_WIDTH = `MAN_WIDTH + `MAN_WIDTH + `EXP_WIDTH,
    parameter int ADDR_WIDTH = 9
) ();
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_par_flip;
    logic                  wr_ready;
    logic                  wr_drop;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_last;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  parity_err;
    logic [1:0]            banks_full;

    modport master (
        output wr_en, wr_addr, wr_data, wr_last, wr_par_flip,
        output rd_en, rd_addr, rd_last,
        input  wr_ready, wr_drop, rd_ready, rd_data, rd_valid,
        input  parity_err, banks_full
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_last, wr_par_flip,
        input  rd_en, rd_addr, rd_last,
        output wr_ready, wr_drop, rd_ready, rd_data, rd_valid,
        output parity_err, banks_full
    );
endinterface

// File: rtl/fft_pingpong_stage_ram.sv
// Ping-pong inter-stage buffer: two banks handed over by frame handshakes.
// Optional FFT_RAM_PARITY_EN adds an even-parity bit per stored word.
`ifndef MAN_WIDTH
`define MAN_WIDTH 16
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 8
`endif

module fft_pingpong_stage_ram #(
    parameter int DATA_WIDTH = `MAN_WIDTH + `MAN_WIDTH + `EXP_WIDTH,
    parameter int ADDR_WIDTH = 9
) (
    input logic                     clk_sys,
    input logic                     rst_sys,
    fft_pingpong_stage_ram_if.slave bus
);
`ifdef FFT_RAM_PARITY_EN
    localparam int WW = DATA_WIDTH + 1;
`else
    localparam int WW = DATA_WIDTH;
`endif
    localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_st_t;

    bank_st_t st_q [2];
    bank_st_t st_d [2];
    logic     wr_bank;
    logic     wr_bank_d;
    logic     rd_bank;
    logic     rd_bank_d;
    logic     wr_ready;
    logic     rd_ready;
    logic     wr_acc;
    logic     rd_acc;
    logic     wr_drop_q;
    logic     rd_valid_q;
    logic [WW-1:0] wr_word;
    logic [WW-1:0] rd_word;
    logic [WW-1:0] mem [DEPTH];

    assign wr_ready = (st_q[wr_bank] == EMPTY);
    assign rd_ready = (st_q[rd_bank] == FULL);
    assign wr_acc   = !bus.wr_en && wr_ready;
    assign rd_acc   = !bus.rd_en && rd_ready;

    // Both lasts in one cycle always hit different banks, so both apply.
    always_comb begin
        st_d[0]   = st_q[0];
        st_d[1]   = st_q[1];
        wr_bank_d = wr_bank;
        rd_bank_d = rd_bank;
        if (wr_acc && bus.wr_last) begin
            st_d[wr_bank] = FULL;
            wr_bank_d     = !wr_bank;
        end
        if (rd_acc && bus.rd_last) begin
            st_d[rd_bank] = EMPTY;
            rd_bank_d     = !rd_bank;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            st_q[0]    <= EMPTY;
            st_q[1]    <= EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_drop_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_word    <= '0;
        end else begin
            st_q[0]    <= st_d[0];
            st_q[1]    <= st_d[1];
            wr_bank    <= wr_bank_d;
            rd_bank    <= rd_bank_d;
            wr_drop_q  <= !bus.wr_en && !wr_ready;
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_word <= mem[{rd_bank, bus.rd_addr}];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_acc) begin
            mem[{wr_bank, bus.wr_addr}] <= wr_word;
        end
    end

`ifdef FFT_RAM_PARITY_EN
    // Stored bit makes the whole word even; a set XOR of all bits is a fault.
    assign wr_word        = {(^bus.wr_data) ^ bus.wr_par_flip, bus.wr_data};
    assign bus.parity_err = rd_valid_q && (^rd_word);
`else
    logic unused_par;
    assign unused_par     = bus.wr_par_flip;
    assign wr_word        = bus.wr_data;
    assign bus.parity_err = 1'b0;
`endif

    assign bus.rd_data    = rd_word[DATA_WIDTH-1:0];
    assign bus.rd_valid   = rd_valid_q;
    assign bus.wr_ready   = wr_ready;
    assign bus.rd_ready   = rd_ready;
    assign bus.wr_drop    = wr_drop_q;
    assign bus.banks_full = {1'b0, st_q[0] == FULL} + {1'b0, st_q[1] == FULL};
endmodule

// File: tb/tb_fft_pingpong_stage_ram.sv
// Scoreboard bench for the ping-pong FFT stage buffer.
// Reads push expected words; the negedge monitor pops them on rd_valid.
module tb_fft_pingpong_stage_ram;
    localparam int DW = 40;
    localparam int AW = 9;
    localparam int N  = 2 ** AW;

    typedef struct {
        logic [DW-1:0] d;
        logic          p;
    } exp_t;

    logic clk = 1'b0;
    logic rst_sys = 1'b1;
    int   total = 0;
    int   bad = 0;

    exp_t          sbq [$];
    logic [DW-1:0] last_rd = '0;
    logic [DW-1:0] mdl [2][N];
    logic          mpar [2][N];
    logic          mfull [2];
    logic          mwb;
    logic          mrb;
    logic          exp_drop;

    always #5 clk = ~clk;

    fft_pingpong_stage_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    fft_pingpong_stage_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_sys(clk),
        .rst_sys(rst_sys),
        .bus    (ifc.slave)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_sys) begin
            if (ifc.rd_valid) begin
                if (sbq.size() == 0) begin
                    chk("rd_spurious", 64'(ifc.rd_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rd_data", 64'(ifc.rd_data), 64'(e.d));
                    chk("parity_err", 64'(ifc.parity_err), 64'(e.p));
                    last_rd = e.d;
                end
            end else begin
                chk("rd_hold", 64'(ifc.rd_data), 64'(last_rd));
                chk("perr_idle", 64'(ifc.parity_err), 64'd0);
            end
        end
    end

    task automatic idle_in();
        ifc.wr_en = 1'b1;
        ifc.wr_addr = '0;
        ifc.wr_data = '0;
        ifc.wr_last = 1'b0;
        ifc.wr_par_flip = 1'b0;
        ifc.rd_en = 1'b1;
        ifc.rd_addr = '0;
        ifc.rd_last = 1'b0;
    endtask

    // One clock: check outputs vs model, drive, advance edge, update model.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic wl, input logic pf, input logic re,
                       input logic [AW-1:0] ra, input logic rl);
        logic wacc;
        logic racc;
        exp_t e;
        chk("wr_ready", 64'(ifc.wr_ready), 64'(!mfull[mwb]));
        chk("rd_ready", 64'(ifc.rd_ready), 64'(mfull[mrb]));
        chk("banks_full", 64'(ifc.banks_full), 64'(int'(mfull[0]) + int'(mfull[1])));
        chk("wr_drop", 64'(ifc.wr_drop), 64'(exp_drop));
        ifc.wr_en = we;
        ifc.wr_addr = wa;
        ifc.wr_data = wd;
        ifc.wr_last = wl;
        ifc.wr_par_flip = pf;
        ifc.rd_en = re;
        ifc.rd_addr = ra;
        ifc.rd_last = rl;
        wacc = !we && !mfull[mwb];
        racc = !re && mfull[mrb];
        exp_drop = !we && mfull[mwb];
        if (racc) begin
            e.d = mdl[mrb][ra];
`ifdef FFT_RAM_PARITY_EN
            e.p = mpar[mrb][ra];
`else
            e.p = 1'b0;
`endif
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (wacc) begin
            mdl[mwb][wa] = wd;
            mpar[mwb][wa] = pf;
            if (wl) begin
                mfull[mwb] = 1'b1;
                mwb = !mwb;
            end
        end
        if (racc && rl) begin
            mfull[mrb] = 1'b0;
            mrb = !mrb;
        end
        idle_in();
    endtask

    task automatic do_reset();
        rst_sys = 1'b1;
        idle_in();
        @(posedge clk);
        @(posedge clk);
        #1;
        mfull[0] = 1'b0;
        mfull[1] = 1'b0;
        mwb = 1'b0;
        mrb = 1'b0;
        exp_drop = 1'b0;
        sbq.delete();
        last_rd = '0;
        rst_sys = 1'b0;
        chk("rst_wr_ready", 64'(ifc.wr_ready), 64'd1);
        chk("rst_rd_ready", 64'(ifc.rd_ready), 64'd0);
        chk("rst_rd_valid", 64'(ifc.rd_valid), 64'd0);
        chk("rst_rd_data", 64'(ifc.rd_data), 64'd0);
        chk("rst_wr_drop", 64'(ifc.wr_drop), 64'd0);
        chk("rst_parity", 64'(ifc.parity_err), 64'd0);
        chk("rst_banks", 64'(ifc.banks_full), 64'd0);
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic wr_frame_rnd(input int flip_addr);
        for (int a = 0; a < N; a++) begin
            cyc(1'b0, AW'(a), rnd(), a == N - 1, a == flip_addr, 1'b1, '0, 1'b0);
        end
    endtask

    task automatic rd_frame(input logic [AW-1:0] xmask);
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, AW'(i) ^ xmask, i == N - 1);
        end
    endtask

    initial begin
        idle_in();
        do_reset();

        // Ascending fill with data=addr; early read requests must be ignored.
        for (int a = 0; a < N; a++) begin
            cyc(1'b0, AW'(a), DW'(a), a == N - 1, 1'b0, 1'b0, AW'(a), 1'b0);
        end
        chk("f1_wr_ready", 64'(ifc.wr_ready), 64'd1);
        chk("f1_rd_ready", 64'(ifc.rd_ready), 64'd1);
        chk("f1_banks", 64'(ifc.banks_full), 64'd1);

        // Descending read, last on address 0.
        for (int a = N - 1; a >= 0; a--) begin
            cyc(1'b1, '0, '0, 1'b0, 1'b0, 1'b0, AW'(a), a == 0);
        end
        cyc(1'b1, '0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        chk("f1_banks_after", 64'(ifc.banks_full), 64'd0);

        // Fill both banks, then a dropped write.
        wr_frame_rnd(-1);
        wr_frame_rnd(-1);
        chk("both_wr_ready", 64'(ifc.wr_ready), 64'd0);
        chk("both_banks", 64'(ifc.banks_full), 64'd2);
        cyc(1'b0, 9'd7, rnd(), 1'b0, 1'b0, 1'b1, '0, 1'b0);
        cyc(1'b1, '0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        cyc(1'b1, '0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0);

        // Drain one bank, then write and read concurrently with shared last.
        rd_frame(9'h000);
        for (int i = 0; i < N; i++) begin
            cyc(1'b0, AW'(i), rnd(), i == N - 1, 1'b0, 1'b0, AW'(N - 1 - i), i == N - 1);
        end
        chk("conc_banks", 64'(ifc.banks_full), 64'd1);
        rd_frame(9'h0a5);
        cyc(1'b1, '0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0);

        // Reset mid-frame, then a frame with a flipped parity bit at addr 5.
        for (int a = 0; a < 100; a++) begin
            cyc(1'b0, AW'(a), rnd(), 1'b0, 1'b0, 1'b1, '0, 1'b0);
        end
        do_reset();
        wr_frame_rnd(5);
        rd_frame(9'h155);
        cyc(1'b1, '0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        cyc(1'b1, '0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
